// File: rtl/lpm_hint_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lpm_hint_pkg
//  Description : Shared types and constants for the LPM hint-string parser.
//                Provides the character constants, the FSM state and field
//                phase encodings, a byte typedef and an ASCII upper-case
//                folding helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lpm_hint_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t CH_COMMA = 8'h2C;
    localparam byte_t CH_EQ    = 8'h3D;
    localparam byte_t CH_SPACE = 8'h20;
    localparam byte_t CH_TAB   = 8'h09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        KEY = 1'b0,
        VAL = 1'b1
    } phase_t;

    // Map a-z onto A-Z; every other byte passes through untouched.
    function automatic byte_t fold_upper(input byte_t c);
        if (c >= 8'h61 && c <= 8'h7A) begin
            return c - 8'h20;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpm_hint_char_class.sv
`default_nettype none
// ============================================================================
//  Module      : lpm_hint_char_class
//  Description : Combinational classifier for one hint-string byte.
//                Flags padding, whitespace, '=' and ',' and produces the
//                byte used for key comparison.  When LPM_HINT_NOCASE_EN is
//                defined the comparison byte is folded to upper case;
//                otherwise it equals the input byte.
//  Ports       : i_ch        - byte under test
//                o_is_pad    - byte is 0x00 (string padding)
//                o_is_ws     - byte is space or tab
//                o_is_eq     - byte is '='
//                o_is_comma  - byte is ','
//                o_folded    - byte used for key comparison
//  Macros      : LPM_HINT_NOCASE_EN - enable case-insensitive key folding
//  Revision    : 1.0 - initial release
// ============================================================================
module lpm_hint_char_class
    import lpm_hint_pkg::*;
(
    input  logic [7:0] i_ch,
    output logic       o_is_pad,
    output logic       o_is_ws,
    output logic       o_is_eq,
    output logic       o_is_comma,
    output logic [7:0] o_folded
);

    assign o_is_pad   = (i_ch == 8'h00);
    assign o_is_ws    = (i_ch == CH_SPACE) || (i_ch == CH_TAB);
    assign o_is_eq    = (i_ch == CH_EQ);
    assign o_is_comma = (i_ch == CH_COMMA);

`ifdef LPM_HINT_NOCASE_EN
    assign o_folded = fold_upper(i_ch);
`else
    assign o_folded = i_ch;
`endif

endmodule
`default_nettype wire

// File: rtl/lpm_hint_parser.sv
`default_nettype none
// ============================================================================
//  Module      : lpm_hint_parser
//  Description : Sequential evaluator for a compile-time hint string of the
//                form "NAME=VALUE, NAME=VALUE".  One byte is consumed per
//                clock, most-significant byte first, for exactly HINT_BYTES
//                cycles.  done pulses HINT_BYTES+1 edges after an accepted
//                start; found/value then hold until the next accepted start.
//  Parameters  : LPM_HINT   - packed hint string, first char in the MS byte
//                HINT_BYTES - byte width of LPM_HINT
//                NAME_BYTES - byte width of the query name (>= 2)
//                VAL_BYTES  - byte width of the returned value (>= 2)
//  Ports       : clock  - rising-edge clock
//                sclr_n - synchronous active-low reset
//                start  - begin a lookup (ignored while busy)
//                name   - right-aligned query name, zero-filled on the left
//                busy   - lookup in progress
//                done   - one-cycle result-valid pulse
//                found  - name present with an '=' binding
//                value  - right-aligned value string, zero if not found
//  Macros      : LPM_HINT_NOCASE_EN - case-insensitive name comparison
//  Revision    : 1.0 - initial release
// ============================================================================
module lpm_hint_parser
    import lpm_hint_pkg::*;
#(
    parameter int                      HINT_BYTES = 256,
    parameter int                      NAME_BYTES = 32,
    parameter int                      VAL_BYTES  = 32,
    parameter logic [8*HINT_BYTES-1:0] LPM_HINT   = "UNUSED"
) (
    input  logic                    clock,
    input  logic                    sclr_n,
    input  logic                    start,
    input  logic [8*NAME_BYTES-1:0] name,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [8*VAL_BYTES-1:0]  value
);

    localparam int c_IDX_W = (HINT_BYTES > 1) ? $clog2(HINT_BYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(HINT_BYTES - 1);

    state_t                  r_state;
    phase_t                  r_phase;
    logic [c_IDX_W-1:0]      r_idx;
    logic [8*NAME_BYTES-1:0] r_name;
    logic [8*NAME_BYTES-1:0] r_key;
    logic                    r_key_ovf;
    logic                    r_match_active;
    logic                    r_matched;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_found;
    logic [8*VAL_BYTES-1:0]  r_value;

    logic [8*NAME_BYTES-1:0] w_name_in;
    logic [7:0]              w_byte;
    logic                    w_is_pad;
    logic                    w_is_ws;
    logic                    w_is_eq;
    logic                    w_is_comma;
    logic [7:0]              w_folded;

    assign busy  = r_busy;
    assign done  = r_done;
    assign found = r_found;
    assign value = r_value;

    // The query name is folded once when latched so the per-byte compare
    // only has to fold the key side.
`ifdef LPM_HINT_NOCASE_EN
    for (genvar g = 0; g < NAME_BYTES; g++) begin : g_name_fold
        assign w_name_in[8*g +: 8] = fold_upper(name[8*g +: 8]);
    end
`else
    assign w_name_in = name;
`endif

    assign w_byte = LPM_HINT[8*r_idx +: 8];

    lpm_hint_char_class u_char_class (
        .i_ch       (w_byte),
        .o_is_pad   (w_is_pad),
        .o_is_ws    (w_is_ws),
        .o_is_eq    (w_is_eq),
        .o_is_comma (w_is_comma),
        .o_folded   (w_folded)
    );

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            r_state        <= IDLE;
            r_phase        <= KEY;
            r_idx          <= '0;
            r_name         <= '0;
            r_key          <= '0;
            r_key_ovf      <= 1'b0;
            r_match_active <= 1'b0;
            r_matched      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_found        <= 1'b0;
            r_value        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_name         <= w_name_in;
                        r_key          <= '0;
                        r_key_ovf      <= 1'b0;
                        r_match_active <= 1'b0;
                        r_matched      <= 1'b0;
                        r_found        <= 1'b0;
                        r_value        <= '0;
                        r_phase        <= KEY;
                        r_idx          <= c_IDX_LAST;
                        r_busy         <= 1'b1;
                        r_state        <= SCAN;
                    end
                end

                SCAN: begin
                    if (!w_is_pad && !w_is_ws) begin
                        if (w_is_comma) begin
                            r_key     <= '0;
                            r_key_ovf <= 1'b0;
                            r_phase   <= KEY;
                            if (r_match_active) begin
                                r_found        <= 1'b1;
                                r_match_active <= 1'b0;
                            end
                        end else if (r_phase == KEY) begin
                            if (w_is_eq) begin
                                // Any '=' ends the key; the rest of the field
                                // is value text, captured only for a match.
                                r_phase <= VAL;
                                if ((r_key == r_name) && !r_key_ovf && !r_matched) begin
                                    r_match_active <= 1'b1;
                                    r_matched      <= 1'b1;
                                end
                            end else begin
                                // Characters are never zero here, so a
                                // non-zero top byte means the key is full.
                                if (r_key[8*NAME_BYTES-1 -: 8] != 8'h00) begin
                                    r_key_ovf <= 1'b1;
                                end
                                r_key <= {r_key[8*NAME_BYTES-9:0], w_folded};
                            end
                        end else if (r_match_active) begin
                            r_value <= {r_value[8*VAL_BYTES-9:0], w_byte};
                        end
                    end

                    if (r_idx == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - c_IDX_W'(1);
                    end
                end

                DONE: begin
                    // A match in the final field has no trailing comma.
                    if (r_match_active) begin
                        r_found        <= 1'b1;
                        r_match_active <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpm_hint_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpm_hint_parser
//  Description : Self-checking bench for lpm_hint_parser.  Six instances
//                share one query bus, each holding a different hint string.
//                Directed table vectors, multi-cycle corner sequences and
//                random queries checked against a string-level model.
//  Macros      : LPM_HINT_NOCASE_EN - expectations follow the same macro
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lpm_hint_parser;

    localparam int HB = 64;
    localparam int NB = 24;
    localparam int VB = 8;
    localparam int NI = 6;

    localparam logic [8*HB-1:0] c_H0 = "INPUT_A_IS_CONSTANT=FIXED, INPUT_A_FIXED_VALUE=1011";
    localparam logic [8*HB-1:0] c_H1 = "UNUSED";
    localparam logic [8*HB-1:0] c_H2 = "A=1, A=2";
    localparam logic [8*HB-1:0] c_H3 = "K=0123456789ABCDEF";
    localparam logic [8*HB-1:0] c_H4 = "Mode=Fast";
    localparam logic [8*HB-1:0] c_H5 = "X=,\tTHIS_KEY_IS_FAR_TOO_LONG_XY=9, B = 7 , AB=5";

    logic                clk;
    logic                sclr_n;
    logic                start;
    logic [8*NB-1:0]     name;
    logic [NI-1:0]       w_busy;
    logic [NI-1:0]       w_done;
    logic [NI-1:0]       w_found;
    logic [8*VB-1:0]     w_value [NI];

    logic [NI-1:0]       cap_found;
    logic [8*VB-1:0]     cap_val [NI];
    logic [8*HB-1:0]     hints [NI];

    int n_err;
    int n_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lpm_hint_parser #(.HINT_BYTES(HB), .NAME_BYTES(NB), .VAL_BYTES(VB), .LPM_HINT(c_H0)) u0 (
        .clock(clk), .sclr_n(sclr_n), .start(start), .name(name),
        .busy(w_busy[0]), .done(w_done[0]), .found(w_found[0]), .value(w_value[0]));
    lpm_hint_parser #(.HINT_BYTES(HB), .NAME_BYTES(NB), .VAL_BYTES(VB), .LPM_HINT(c_H1)) u1 (
        .clock(clk), .sclr_n(sclr_n), .start(start), .name(name),
        .busy(w_busy[1]), .done(w_done[1]), .found(w_found[1]), .value(w_value[1]));
    lpm_hint_parser #(.HINT_BYTES(HB), .NAME_BYTES(NB), .VAL_BYTES(VB), .LPM_HINT(c_H2)) u2 (
        .clock(clk), .sclr_n(sclr_n), .start(start), .name(name),
        .busy(w_busy[2]), .done(w_done[2]), .found(w_found[2]), .value(w_value[2]));
    lpm_hint_parser #(.HINT_BYTES(HB), .NAME_BYTES(NB), .VAL_BYTES(VB), .LPM_HINT(c_H3)) u3 (
        .clock(clk), .sclr_n(sclr_n), .start(start), .name(name),
        .busy(w_busy[3]), .done(w_done[3]), .found(w_found[3]), .value(w_value[3]));
    lpm_hint_parser #(.HINT_BYTES(HB), .NAME_BYTES(NB), .VAL_BYTES(VB), .LPM_HINT(c_H4)) u4 (
        .clock(clk), .sclr_n(sclr_n), .start(start), .name(name),
        .busy(w_busy[4]), .done(w_done[4]), .found(w_found[4]), .value(w_value[4]));
    lpm_hint_parser #(.HINT_BYTES(HB), .NAME_BYTES(NB), .VAL_BYTES(VB), .LPM_HINT(c_H5)) u5 (
        .clock(clk), .sclr_n(sclr_n), .start(start), .name(name),
        .busy(w_busy[5]), .done(w_done[5]), .found(w_found[5]), .value(w_value[5]));

    typedef struct {
        int    inst;
        string q;
        bit    f;
        string v;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int inst, input string q, input bit f, input string v);
        vec_t t;
        t.inst = inst;
        t.q    = q;
        t.f    = f;
        t.v    = v;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [8*NB-1:0] pack_name(input string s);
        logic [8*NB-1:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[8*NB-9:0], s[i]};
        return v;
    endfunction

    function automatic logic [8*VB-1:0] pack_val(input string s);
        logic [8*VB-1:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[8*VB-9:0], s[i]};
        return v;
    endfunction

    function automatic byte unsigned fold(input byte unsigned c);
`ifdef LPM_HINT_NOCASE_EN
        if (c >= "a" && c <= "z") return c - 8'd32;
`endif
        return c;
    endfunction

    // String-level reference: drop padding/whitespace, split on commas, the
    // first '=' in a field separates key from value, first matching key wins.
    function automatic void ref_lookup(input logic [8*HB-1:0] h, input string q,
                                       output bit f, output logic [8*VB-1:0] v);
        byte unsigned fld[$];
        byte unsigned c;
        int           eq;
        bit           same;
        f = 1'b0;
        v = '0;
        for (int i = HB - 1; i >= -1; i--) begin
            if (i >= 0) c = h[8*i +: 8];
            else        c = ",";
            if (c == 0 || c == " " || c == "\t") continue;
            if (c != ",") begin
                fld.push_back(c);
                continue;
            end
            if (!f) begin
                eq = -1;
                for (int k = 0; k < fld.size(); k++)
                    if (eq < 0 && fld[k] == "=") eq = k;
                if (eq >= 0 && eq <= NB && eq == q.len()) begin
                    same = 1'b1;
                    for (int k = 0; k < eq; k++)
                        if (fold(fld[k]) != fold(q[k])) same = 1'b0;
                    if (same) begin
                        f = 1'b1;
                        for (int k = eq + 1; k < fld.size(); k++) v = {v[8*VB-9:0], fld[k]};
                    end
                end
            end
            fld.delete();
        end
    endfunction

    // Issue a lookup and check busy/done timing on every instance.  An
    // optional second start is pulsed at SCAN edge glitch_edge.
    task automatic run_lookup(input string q, input int glitch_edge, input string gq);
        bit early;
        early = 1'b0;
        @(negedge clk);
        name  = pack_name(q);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= HB; e++) begin
            if (e == glitch_edge) begin
                name  = pack_name(gq);
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            if (w_done != '0 || w_busy != '1) early = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("no_early_done", 64'(early), 64'd0);
        chk("done_at_latency", {52'd0, w_busy, w_done}, {52'd0, 6'h00, 6'h3F});
        cap_found = w_found;
        for (int i = 0; i < NI; i++) cap_val[i] = w_value[i];
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(w_done), 64'd0);
    endtask

    initial begin
        bit              mf;
        logic [8*VB-1:0] mv;
        bit              bad;
        string           cands[$];
        string           alpha;
        string           q;

        n_err  = 0;
        n_chk  = 0;
        sclr_n = 1'b0;
        start  = 1'b0;
        name   = '0;
        hints[0] = c_H0; hints[1] = c_H1; hints[2] = c_H2;
        hints[3] = c_H3; hints[4] = c_H4; hints[5] = c_H5;

        add_vec(0, "INPUT_A_IS_CONSTANT", 1'b1, "FIXED");
        add_vec(0, "INPUT_A_FIXED_VALUE", 1'b1, "1011");
        add_vec(0, "INPUT_B_IS_CONSTANT", 1'b0, "");
        add_vec(0, "INPUT_A",             1'b0, "");
        add_vec(1, "UNUSED",              1'b0, "");
        add_vec(2, "A",                   1'b1, "1");
        add_vec(2, "AB",                  1'b0, "");
        add_vec(3, "K",                   1'b1, "89ABCDEF");
`ifdef LPM_HINT_NOCASE_EN
        add_vec(4, "MODE",                1'b1, "Fast");
`else
        add_vec(4, "MODE",                1'b0, "");
`endif
        add_vec(4, "Mode",                1'b1, "Fast");
        add_vec(5, "X",                   1'b1, "");
        add_vec(5, "B",                   1'b1, "7");
        add_vec(5, "AB",                  1'b1, "5");
        add_vec(5, "A",                   1'b0, "");
        add_vec(5, "S_KEY_IS_FAR_TOO_LONG_XY", 1'b0, "");

        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {46'd0, w_busy, w_done, w_found}, 64'd0);
        chk("reset_value", w_value[0], 64'd0);
        @(negedge clk);
        sclr_n = 1'b1;

        // Directed table.
        foreach (tbl[i]) begin
            run_lookup(tbl[i].q, 0, "");
            chk($sformatf("tbl%0d_found", i), 64'(cap_found[tbl[i].inst]), 64'(tbl[i].f));
            chk($sformatf("tbl%0d_value", i), cap_val[tbl[i].inst], pack_val(tbl[i].v));
        end

        // A second start while busy must not disturb the running lookup.
        run_lookup("INPUT_A_FIXED_VALUE", 10, "INPUT_A_IS_CONSTANT");
        chk("busy_start_found", 64'(cap_found[0]), 64'd1);
        chk("busy_start_value", cap_val[0], pack_val("1011"));

        // Reset mid-scan, after the first field has already been resolved.
        @(negedge clk);
        name  = pack_name("INPUT_A_IS_CONSTANT");
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (45) @(negedge clk);
        chk("midscan_found_pre", 64'(w_found[0]), 64'd1);
        sclr_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_flags", {46'd0, w_busy, w_done, w_found}, 64'd0);
        chk("midreset_value", w_value[0], 64'd0);
        @(negedge clk);
        sclr_n = 1'b1;
        bad = 1'b0;
        for (int e = 0; e < HB + 4; e++) begin
            @(posedge clk);
            #1;
            if (w_done != '0 || w_busy != '0) bad = 1'b1;
        end
        chk("no_done_after_reset", 64'(bad), 64'd0);
        run_lookup("INPUT_A_IS_CONSTANT", 0, "");
        chk("post_reset_found", 64'(cap_found[0]), 64'd1);
        chk("post_reset_value", cap_val[0], pack_val("FIXED"));

        // Random queries against the model, all instances at once.
        cands = '{"INPUT_A_IS_CONSTANT", "INPUT_A_FIXED_VALUE", "INPUT_B_IS_CONSTANT",
                  "UNUSED", "A", "AB", "B", "K", "X", "Mode", "MODE", "mode",
                  "FIXED", "S_KEY_IS_FAR_TOO_LONG_XY", "KK", "input_a_is_constant"};
        alpha = "ABKXm";
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                q = "";
                for (int k = 0; k <= int'($urandom_range(0, 2)); k++) begin
                    int p;
                    p = int'($urandom_range(0, 4));
                    q = {q, alpha.substr(p, p)};
                end
            end else begin
                q = cands[$urandom_range(0, cands.size() - 1)];
            end
            run_lookup(q, 0, "");
            for (int i = 0; i < NI; i++) begin
                ref_lookup(hints[i], q, mf, mv);
                chk($sformatf("rnd_found u%0d '%s'", i, q), 64'(cap_found[i]), 64'(mf));
                chk($sformatf("rnd_value u%0d '%s'", i, q), cap_val[i], mv);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
